// File: rtl/data_mem_512x8_pkg.sv
// Shared constants and helpers for the 512x8 big-endian data memory.
package data_mem_512x8_pkg;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  // Natural alignment check on the two low address bits; size 11 is never legal.
  function automatic logic size_aligned(input logic [1:0] addr_lo, input size_e size);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_512x8_if.sv
// Core load/store bus plus byte-stream preload port of the data memory.
interface data_mem_512x8_if
  import data_mem_512x8_pkg::*;
();
  logic              enable;
  logic              rw;
  logic [1:0]        size;
  logic              se;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              misalign;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;

  modport master (
    output enable, rw, size, se, address, data_in, ld_valid, ld_byte,
    input  data_out, data_valid, misalign, ld_ready, ld_addr
  );

  modport slave (
    input  enable, rw, size, se, address, data_in, ld_valid, ld_byte,
    output data_out, data_valid, misalign, ld_ready, ld_addr
  );
endinterface

// File: rtl/data_mem_512x8_format.sv
// Alignment check and load-data extension; raw_i holds M[A..A+3], M[A] in the MSB.
module data_mem_512x8_format
  import data_mem_512x8_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  input  logic [31:0] raw_i,
  output logic        aligned_o,
  output logic [31:0] ext_o
);

  size_e size;
  assign size = size_e'(size_i);

  // Byte/half are taken from the top of raw_i because the addressed byte is the MSB.
  always_comb begin
    aligned_o = size_aligned(addr_lo_i, size);
    ext_o     = '0;
    case (size)
      SIZE_BYTE: ext_o = se_i ? {{24{raw_i[31]}}, raw_i[31:24]} : {24'b0, raw_i[31:24]};
      SIZE_HALF: ext_o = se_i ? {{16{raw_i[31]}}, raw_i[31:16]} : {16'b0, raw_i[31:16]};
      SIZE_WORD: ext_o = raw_i;
      default:   ext_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_512x8.sv
// 512x8 byte-addressed big-endian data memory with registered load path and preload port.
module data_mem_512x8
  import data_mem_512x8_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  data_mem_512x8_if.slave bus
);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] lane_addr  [4];
  logic [ADDR_W-1:0] lane_waddr [4];
  logic [7:0]        lane_wdata [4];
  logic [3:0]        lane_we;
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic [31:0]       st_word;
  logic              aligned;
  logic              core_go;
  logic              ld_ready;

  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;

  assign core_go  = bus.enable & ~clr;
  assign ld_ready = bus.ld_valid & ~bus.enable & ~clr;

  // Byte lane k addresses M[A+k]; lanes past the access size are simply unused.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = bus.address + ADDR_W'(k);
    end
  end

  assign raw = {mem_q[lane_addr[0]], mem_q[lane_addr[1]],
                mem_q[lane_addr[2]], mem_q[lane_addr[3]]};

  data_mem_512x8_format u_format (
    .addr_lo_i (bus.address[1:0]),
    .size_i    (bus.size),
    .se_i      (bus.se),
    .raw_i     (raw),
    .aligned_o (aligned),
    .ext_o     (ext)
  );

  // Left-justify store data so lane 0 always carries the most significant stored byte.
  always_comb begin
    st_word = bus.data_in;
    case (bus.size)
      SIZE_BYTE: st_word = bus.data_in << 24;
      SIZE_HALF: st_word = bus.data_in << 16;
      default:   st_word = bus.data_in;
    endcase
  end

  // Write-enable decode; preload only reaches the array when the core is idle.
  always_comb begin
    lane_we = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      lane_waddr[k] = lane_addr[k];
      lane_wdata[k] = st_word[31-8*k -: 8];
    end
    if (core_go && (bus.rw == RW_STORE) && aligned) begin
      case (bus.size)
        SIZE_BYTE: lane_we = 4'b0001;
        SIZE_HALF: lane_we = 4'b0011;
        SIZE_WORD: lane_we = 4'b1111;
        default:   lane_we = 4'b0000;
      endcase
    end else if (ld_ready) begin
      lane_we       = 4'b0001;
      lane_waddr[0] = ld_addr_q;
      lane_wdata[0] = bus.ld_byte;
    end
  end

  // Byte array write; contents deliberately survive clr.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        mem_q[lane_waddr[k]] <= lane_wdata[k];
      end
    end
  end

  // Next-state for load result, status flags and preload pointer.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    misalign_d   = 1'b0;
    ld_addr_d    = ld_addr_q;
    if (bus.enable) begin
      if (!aligned) begin
        misalign_d = 1'b1;
      end else if (bus.rw == RW_LOAD) begin
        data_out_d   = ext;
        data_valid_d = 1'b1;
      end
    end else if (ld_ready) begin
      ld_addr_d = (ld_addr_q == ADDR_W'(DEPTH-1)) ? '0 : ld_addr_q + 1'b1;
    end
  end

  // Output and pointer registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      ld_addr_q    <= '0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      misalign_q   <= misalign_d;
      ld_addr_q    <= ld_addr_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.ld_addr    = ld_addr_q;
  assign bus.ld_ready   = ld_ready;

endmodule
